// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words behind a 2-entry output buffer.
// Optional immediate range checking is compiled in with `define ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam int unsigned INSTR_W = 32;

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_ISHFT = 3'd6;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [INSTR_W-1:0]   r_head;
    logic [INSTR_W-1:0]   r_tail;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_err;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_load_head;
    logic                 w_load_tail;
    logic                 w_shift;
    logic [INSTR_W-1:0]   w_word;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // Field packing; out-of-range immediates are simply truncated.
    always_comb begin
        w_word = NOP_WORD;
        case (fmt)
            FMT_R:     w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:     w_word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:     w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:     w_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                 imm[4:1], imm[11], opcode};
            FMT_U:     w_word = {imm[31:12], rd, opcode};
            FMT_J:     w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_ISHFT: w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            default:   w_word = NOP_WORD;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic w_i_ok;
    logic w_b_ok;
    logic w_j_ok;
    logic w_rng_bad;

    assign w_i_ok = (&imm[31:11]) || !(|imm[31:11]);
    assign w_b_ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
    assign w_j_ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];

    // Immediate range / format legality for the bundle currently offered.
    always_comb begin
        w_rng_bad = 1'b0;
        case (fmt)
            FMT_R:     w_rng_bad = 1'b0;
            FMT_I:     w_rng_bad = !w_i_ok;
            FMT_S:     w_rng_bad = !w_i_ok;
            FMT_B:     w_rng_bad = !w_b_ok;
            FMT_U:     w_rng_bad = |imm[11:0];
            FMT_J:     w_rng_bad = !w_j_ok;
            FMT_ISHFT: w_rng_bad = |imm[31:5];
            default:   w_rng_bad = 1'b1;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Buffer occupancy FSM; FULL never accepts, so push and pop only coincide in ONE.
    always_comb begin
        w_state_n   = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_load_head = 1'b1;
                    w_state_n   = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_load_head = 1'b1;
                end else if (w_push) begin
                    w_load_tail = 1'b1;
                    w_state_n   = S_FULL;
                end else if (w_pop) begin
                    w_state_n   = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_shift   = 1'b1;
                    w_state_n = S_ONE;
                end
            end
            default: begin
                w_state_n = S_EMPTY;
            end
        endcase
    end

    // in_ready comes up on the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_n != S_FULL);
            r_out_valid <= (w_state_n != S_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_word;
            end else if (w_shift) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_word;
            end
        end
    end

    // Clear beats a same-cycle pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (addr_clr) begin
            r_addr <= '0;
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // A failing accept in the same cycle as a clear leaves err set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
`ifdef ENC_RANGE_CHECK_EN
            r_err <= (r_err && !addr_clr) || (w_push && w_rng_bad);
`else
            r_err <= 1'b0;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_head;
    assign out_addr  = r_addr;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expectations are hand-encoded words.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 10;

`ifdef ENC_RANGE_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              addr_clr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .addr_clr  (addr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt      = f;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
        in_valid = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        fmt       = '0;
        opcode    = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        funct3    = '0;
        funct7    = '0;
        imm       = '0;
        addr_clr  = 1'b0;
        out_ready = 1'b1;

        repeat (2) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr",  32'(out_addr), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        reset = 1'b0;
        tick();
        check("rdy_after_rst", 32'(in_ready), 32'd1);

        // single I-type, one-cycle latency
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        check("i_valid", 32'(out_valid), 32'd1);
        check("i_instr", out_instr, 32'h0050_0093);
        check("i_addr",  32'(out_addr), 32'd0);
        check("i_err",   32'(err), 32'd0);
        tick();
        check("i_popped", 32'(out_valid), 32'd0);
        check("i_addr_inc", 32'(out_addr), 32'd1);
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        check("clr_addr", 32'(out_addr), 32'd0);

        // R then S streamed back to back
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        tick();
        check("r_instr", out_instr, 32'h0020_81B3);
        check("r_addr",  32'(out_addr), 32'd0);
        drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        tick();
        in_valid = 1'b0;
        check("s_instr", out_instr, 32'h0020_A423);
        check("s_addr",  32'(out_addr), 32'd1);
        tick();
        check("rs_drain_valid", 32'(out_valid), 32'd0);
        check("rs_drain_addr",  32'(out_addr), 32'd2);

        // B, U, J, I-shift streamed
        drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        tick();
        check("b_instr", out_instr, 32'hFE00_0EE3);
        check("b_addr",  32'(out_addr), 32'd2);
        check("b_err",   32'(err), 32'd0);
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        tick();
        check("u_instr", out_instr, 32'h1234_52B7);
        check("u_addr",  32'(out_addr), 32'd3);
        drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        tick();
        check("j_instr", out_instr, 32'h0010_00EF);
        drive(3'd6, 7'h13, 5'd4, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3);
        tick();
        in_valid = 1'b0;
        check("sh_instr", out_instr, 32'h4031_5213);
        check("sh_addr",  32'(out_addr), 32'd5);
        check("legal_err", 32'(err), 32'd0);
        tick();
        check("bu_drain_addr", 32'(out_addr), 32'd6);

        // backpressure: fill, stall, drain in order
        addr_clr = 1'b1;
        tick();
        addr_clr  = 1'b0;
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        check("bp1_ready", 32'(in_ready), 32'd1);
        check("bp1_instr", out_instr, 32'h0010_0093);
        drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        tick();
        check("bp2_ready", 32'(in_ready), 32'd0);
        drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        tick();
        check("bp3_ready_low", 32'(in_ready), 32'd0);
        check("bp3_hold_instr", out_instr, 32'h0010_0093);
        check("bp3_hold_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_instr", out_instr, 32'h0020_0113);
        check("bp_pop1_addr",  32'(out_addr), 32'd1);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_pop2_instr", out_instr, 32'h0030_0193);
        check("bp_pop2_addr",  32'(out_addr), 32'd2);
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_drain_addr",  32'(out_addr), 32'd3);

        // out-of-range I immediate, sticky err, clear wins over pop
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        tick();
        in_valid = 1'b0;
        check("ovf_instr", out_instr, 32'h8000_0093);
        check("ovf_err", 32'(err), EXP_ERR);
        tick();
        check("ovf_err_sticky", 32'(err), EXP_ERR);
        out_ready = 1'b1;
        addr_clr  = 1'b1;
        tick();
        addr_clr = 1'b0;
        check("clr_pop_addr", 32'(out_addr), 32'd0);
        check("clr_pop_err",  32'(err), 32'd0);
        check("clr_pop_valid", 32'(out_valid), 32'd0);

        // erroneous accept coinciding with clear leaves err set
        out_ready = 1'b0;
        addr_clr  = 1'b1;
        drive(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0123);
        tick();
        in_valid = 1'b0;
        addr_clr = 1'b0;
        check("u_bad_instr", out_instr, 32'h0000_0037);
        check("u_bad_err", 32'(err), EXP_ERR);
        out_ready = 1'b1;
        tick();
        check("u_bad_pop_addr", 32'(out_addr), 32'd1);

        // reserved format emits nop
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        check("pre_rsv_err", 32'(err), 32'd0);
        drive(3'd7, 7'h33, 5'd7, 5'd1, 5'd2, 3'd1, 7'h20, 32'h1234_5678);
        tick();
        in_valid = 1'b0;
        check("rsv_instr", out_instr, 32'h0000_0013);
        check("rsv_err", 32'(err), EXP_ERR);
        tick();
        check("rsv_pop_addr", 32'(out_addr), 32'd1);

        // reset with two words buffered
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_addr",  32'(out_addr), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_addr",  32'(out_addr), 32'd0);
        check("midrst_instr", out_instr, 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        check("post_rst_instr", out_instr, 32'h0050_0093);
        check("post_rst_addr",  32'(out_addr), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: packs decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, immediate) into 32-bit instruction words.
- Used by the program loader / self-test generator to write instruction memory.
- Valid/ready input, 2-entry output buffer, word-address counter, immediate range checking.

Parameters:
ADDR_W, 10, width of word-address counter out_addr; wraps modulo 2^ADDR_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle
fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6=I-shift 7=reserved
opcode  input  7  instr[6:0]
rd  input  5  destination register
rs1  input  5  source 1
rs2  input  5  source 2
funct3  input  3  instr[14:12]
funct7  input  7  instr[31:25] (R, I-shift)
imm  input  32  full signed/byte immediate value
addr_clr  input  1  synchronous clear of out_addr and err
out_valid  output  1  out_instr valid
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  word address of current out_instr
err  output  1  sticky range/format error

Behaviour:
- Async reset: buffer emptied, out_valid=0, out_instr=0, out_addr=0, err=0, in_ready=1 on first edge after release.
- Input handshake: accept when in_valid && in_ready; in_ready = (buffer count < 2). No combinational in->out path.
- Encoding, registered into buffer tail on accept:
  R: funct7|rs2|rs1|funct3|rd|opcode.
  I: imm[11:0]|rs1|funct3|rd|opcode.
  S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  U: imm[31:12]|rd|opcode.
  J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  I-shift: funct7|imm[4:0]|rs1|funct3|rd|opcode.
  Reserved: 0x00000013 (nop).
- Range check (per fmt), failure sets err; word still encoded from truncated bits:
  I/S: imm[31:11] all equal.
  B: imm[31:12] all equal and imm[0]=0.
  J: imm[31:20] all equal and imm[0]=0.
  U: imm[11:0]=0.
  I-shift: imm[31:5]=0.
  fmt=7: always error.
  R: never.
- Latency: accept at edge N -> out_valid=1 with the word after edge N if buffer was empty; otherwise the word queues behind the head, FIFO order.
- Output: out_instr/out_addr hold stable while out_valid && !out_ready. On out_valid && out_ready, head pops and out_addr increments by 1, wrapping 2^ADDR_W-1 -> 0.
- Simultaneous push and pop: count unchanged, order preserved. Full (count=2): in_ready=0 even if out_ready=1 the same cycle (no pass-through).
- addr_clr: out_addr<=0 and err<=0 next edge; buffer untouched. If it coincides with a pop, clear wins. If it coincides with an erroneous accept, err ends at 1.
- Reset mid-stream: buffered words discarded, no partial output.

Optional Feature:
ENC_RANGE_CHECK_EN
- Defined: range checks as above, err sticky.
- Undefined: no checks; err tied to 0. fmt=7 still emits nop. Encodings identical.

Test Plan:
- I, op=0x13 rd=1 rs1=0 f3=0 imm=5, out_ready=1 -> out_instr=0x00500093 one cycle after accept, out_addr=0, err=0.
- R, op=0x33 rd=3 rs1=1 rs2=2 f3=0 f7=0, then S, op=0x23 rs1=1 rs2=2 f3=2 imm=8 -> 0x002081B3 at addr 0, then 0x0020A423 at addr 1.
- B, op=0x63 rs1=0 rs2=0 f3=0 imm=-4 -> 0xFE000EE3; U, op=0x37 rd=5 imm=0x12345000 -> 0x123452B7.
- out_ready=0, three back-to-back bundles -> in_ready drops after second accept. Raise out_ready -> third accepted, three words in order, out_addr 0,1,2.
- I with imm=0x800 -> out_instr[31:20]=0x800, err=1 and held; addr_clr pulse -> err=0, out_addr=0. Macro undefined -> err stays 0.
- Reset asserted with 2 words buffered -> out_valid=0, out_addr=0 immediately; next accept after release starts at addr 0.
